// File: rtl/arq_pkg.sv
// Shared encodings and context reset values for the ARQ/flow-control engine.
package arq_pkg;

  localparam logic [1:0] SEL_NEW        = 2'd0;
  localparam logic [1:0] SEL_RETX       = 2'd1;
  localparam logic [1:0] SEL_EMPTY_CONT = 2'd2;
  localparam logic [1:0] SEL_HOLD       = 2'd3;

  localparam logic [1:0] CLS_NULL  = 2'd0;
  localparam logic [1:0] CLS_ACL   = 2'd1;
  localparam logic [1:0] CLS_OTHER = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    FLUSH    = 2'd2
  } arq_state_e;

  localparam logic       RST_SEQN_TX  = 1'b1;
  localparam logic       RST_SEQN_OLD = 1'b0;
  localparam logic       RST_ARQN     = 1'b0;
  localparam logic       RST_RFLOW    = 1'b1;
  localparam arq_state_e RST_STATE    = IDLE;

endpackage

// File: rtl/arq_lt_ctx.sv
// One LT_ADDR context: TX state machine, retransmission counter, SEQN/ARQN/FLOW bits.
module arq_lt_ctx
  import arq_pkg::*;
#(
  parameter int RTXW = 8
) (
  input  logic            clk_6M,
  input  logic            rstz,
  input  logic            clr,
  input  logic            hdr_en,
  input  logic            hdr_arqn,
  input  logic            hdr_flow,
  input  logic            py_fail,
  input  logic            py_en,
  input  logic            py_seqn,
  input  logic [1:0]      py_class,
  input  logic            py_crc_good,
  input  logic            py_buf_ready,
  input  logic            tx_en,
  input  logic            tx_is_data,
  input  logic            flush_en,
  input  logic [RTXW-1:0] max_rtx,
  output logic            seqn_tx,
  output logic            arqn,
  output logic [1:0]      dec_sel,
  output logic            accept_p,
  output logic            dup_p,
  output logic            abort_p,
  output logic            flush_done_p
);

  arq_state_e      state_q, state_d;
  logic [RTXW-1:0] rtx_cnt_q, rtx_cnt_d;
  logic            seqn_tx_q, seqn_tx_d;
  logic            seqn_old_q, seqn_old_d;
  logic            arqn_q, arqn_d;
  logic            rflow_q, rflow_d;
  logic            rtx_limit;

  assign rtx_limit = (max_rtx != '0) && (rtx_cnt_q == max_rtx);
  assign seqn_tx   = seqn_tx_q;
  assign arqn      = arqn_q;

  always_comb begin
    state_d      = state_q;
    rtx_cnt_d    = rtx_cnt_q;
    seqn_tx_d    = seqn_tx_q;
    seqn_old_d   = seqn_old_q;
    arqn_d       = arqn_q;
    rflow_d      = rflow_q;
    dec_sel      = SEL_HOLD;
    accept_p     = 1'b0;
    dup_p        = 1'b0;
    abort_p      = 1'b0;
    flush_done_p = 1'b0;

    // Decision always reflects the state as it stood before this cycle's updates.
    if (!tx_is_data)             dec_sel = SEL_NEW;
    else if (state_q == FLUSH)   dec_sel = SEL_EMPTY_CONT;
    else if (!rflow_q)           dec_sel = SEL_HOLD;
    else if (state_q == IDLE)    dec_sel = SEL_NEW;
    else if (rtx_limit)          dec_sel = SEL_EMPTY_CONT;
    else                         dec_sel = SEL_RETX;

    if (tx_en && tx_is_data && rflow_q) begin
      if (state_q == IDLE) begin
        state_d = WAIT_ACK;
      end else if (state_q == WAIT_ACK) begin
        if (rtx_limit) begin
          state_d = FLUSH;
          abort_p = 1'b1;
        end else if (rtx_cnt_q != '1) begin
          rtx_cnt_d = rtx_cnt_q + RTXW'(1);
        end
      end
    end

    if (flush_en && state_q == WAIT_ACK) state_d = FLUSH;

    // An ACK overrides both the TX transition and a flush request.
    if (hdr_en) begin
      rflow_d = hdr_flow;
      if (hdr_arqn && state_q != IDLE) begin
        seqn_tx_d    = ~seqn_tx_q;
        rtx_cnt_d    = '0;
        state_d      = IDLE;
        flush_done_p = (state_q == FLUSH);
      end
    end

    if (py_fail) arqn_d = 1'b0;

    if (py_en) begin
      case (py_class)
        CLS_NULL: arqn_d = arqn_q;
        CLS_ACL: begin
          if (py_seqn != seqn_old_q) begin
            if (py_crc_good && py_buf_ready) begin
              seqn_old_d = py_seqn;
              arqn_d     = 1'b1;
              accept_p   = 1'b1;
            end else begin
              arqn_d = 1'b0;
            end
          end else begin
            arqn_d = 1'b1;
            dup_p  = 1'b1;
          end
        end
        CLS_OTHER: arqn_d = 1'b0;
        default:   arqn_d = 1'b0;
      endcase
    end

    if (clr) begin
      state_d      = RST_STATE;
      rtx_cnt_d    = '0;
      seqn_tx_d    = RST_SEQN_TX;
      seqn_old_d   = RST_SEQN_OLD;
      arqn_d       = RST_ARQN;
      rflow_d      = RST_RFLOW;
      accept_p     = 1'b0;
      dup_p        = 1'b0;
      abort_p      = 1'b0;
      flush_done_p = 1'b0;
    end
  end

  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      state_q    <= RST_STATE;
      rtx_cnt_q  <= '0;
      seqn_tx_q  <= RST_SEQN_TX;
      seqn_old_q <= RST_SEQN_OLD;
      arqn_q     <= RST_ARQN;
      rflow_q    <= RST_RFLOW;
    end else begin
      state_q    <= state_d;
      rtx_cnt_q  <= rtx_cnt_d;
      seqn_tx_q  <= seqn_tx_d;
      seqn_old_q <= seqn_old_d;
      arqn_q     <= arqn_d;
      rflow_q    <= rflow_d;
    end
  end

endmodule

// File: rtl/arq_flow_engine.sv
// ARQ/flow-control engine: decodes LT indices into NLT contexts and registers the muxed results.
module arq_flow_engine
  import arq_pkg::*;
#(
  parameter int NLT  = 8,
  parameter int LTW  = 3,
  parameter int RTXW = 8
) (
  input  logic            clk_6M,
  input  logic            rstz,
  input  logic            conn_new_p,
  input  logic [LTW-1:0]  conn_lt,
  input  logic [RTXW-1:0] regi_max_rtx,
  input  logic            rx_hdr_p,
  input  logic            rx_py_end_p,
  input  logic            rx_cac,
  input  logic            rx_hec_good,
  input  logic            rx_addressed,
  input  logic [LTW-1:0]  rx_lt_addr,
  input  logic [LTW-1:0]  rx_exp_lt,
  input  logic            rx_seqn,
  input  logic            rx_arqn,
  input  logic            rx_flow,
  input  logic [1:0]      rx_class,
  input  logic            rx_crc_good,
  input  logic            rx_buf_ready,
  input  logic            tx_req_p,
  input  logic [LTW-1:0]  tx_lt,
  input  logic            tx_is_data,
  input  logic            flush_req_p,
  input  logic [LTW-1:0]  flush_lt,
  output logic            tx_dec_valid,
  output logic [1:0]      tx_sel,
  output logic            tx_seqn,
  output logic            tx_arqn,
  output logic            tx_flow,
  output logic            rx_accept_p,
  output logic            rx_dup_p,
  output logic            rtx_abort_p,
  output logic            flush_done_p
);

  logic           rx_good;
  logic [NLT-1:0] seqn_vec, arqn_vec, acc_vec, dup_vec, abort_vec, done_vec;
  logic [1:0]     sel_arr [NLT];

  assign rx_good = rx_cac && rx_hec_good;

  // Indices >= NLT match no context, so they are dropped by construction.
  for (genvar gi = 0; gi < NLT; gi++) begin : g_lt
    arq_lt_ctx #(.RTXW(RTXW)) u_ctx (
      .clk_6M       (clk_6M),
      .rstz         (rstz),
      .clr          (conn_new_p && (conn_lt == LTW'(gi))),
      .hdr_en       (rx_hdr_p && rx_good && rx_addressed && (rx_lt_addr == LTW'(gi))),
      .hdr_arqn     (rx_arqn),
      .hdr_flow     (rx_flow),
      .py_fail      (rx_py_end_p && !rx_good && (rx_exp_lt == LTW'(gi))),
      .py_en        (rx_py_end_p && rx_good && rx_addressed && (rx_lt_addr == LTW'(gi))),
      .py_seqn      (rx_seqn),
      .py_class     (rx_class),
      .py_crc_good  (rx_crc_good),
      .py_buf_ready (rx_buf_ready),
      .tx_en        (tx_req_p && (tx_lt == LTW'(gi))),
      .tx_is_data   (tx_is_data),
      .flush_en     (flush_req_p && (flush_lt == LTW'(gi))),
      .max_rtx      (regi_max_rtx),
      .seqn_tx      (seqn_vec[gi]),
      .arqn         (arqn_vec[gi]),
      .dec_sel      (sel_arr[gi]),
      .accept_p     (acc_vec[gi]),
      .dup_p        (dup_vec[gi]),
      .abort_p      (abort_vec[gi]),
      .flush_done_p (done_vec[gi])
    );
  end

  logic [1:0] dec_sel;
  logic       dec_seqn, dec_arqn;
  logic       tx_dec_valid_q, tx_dec_valid_d;
  logic [1:0] tx_sel_q, tx_sel_d;
  logic       tx_seqn_q, tx_seqn_d, tx_arqn_q, tx_arqn_d, tx_flow_q, tx_flow_d;
  logic       rx_accept_q, rx_accept_d, rx_dup_q, rx_dup_d;
  logic       rtx_abort_q, rtx_abort_d, flush_done_q, flush_done_d;

  always_comb begin
    dec_sel  = SEL_HOLD;
    dec_seqn = 1'b0;
    dec_arqn = 1'b0;
    for (int i = 0; i < NLT; i++) begin
      if (tx_lt == LTW'(i)) begin
        dec_sel  = sel_arr[i];
        dec_seqn = seqn_vec[i];
        dec_arqn = arqn_vec[i];
      end
    end

    tx_dec_valid_d = tx_req_p;
    tx_sel_d       = tx_req_p ? dec_sel  : tx_sel_q;
    tx_seqn_d      = tx_req_p ? dec_seqn : tx_seqn_q;
    tx_arqn_d      = tx_req_p ? dec_arqn : tx_arqn_q;
    tx_flow_d      = rx_buf_ready;
    rx_accept_d    = |acc_vec;
    rx_dup_d       = |dup_vec;
    rtx_abort_d    = |abort_vec;
    flush_done_d   = |done_vec;
  end

  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      tx_dec_valid_q <= 1'b0;
      tx_sel_q       <= 2'd0;
      tx_seqn_q      <= 1'b0;
      tx_arqn_q      <= 1'b0;
      tx_flow_q      <= 1'b1;
      rx_accept_q    <= 1'b0;
      rx_dup_q       <= 1'b0;
      rtx_abort_q    <= 1'b0;
      flush_done_q   <= 1'b0;
    end else begin
      tx_dec_valid_q <= tx_dec_valid_d;
      tx_sel_q       <= tx_sel_d;
      tx_seqn_q      <= tx_seqn_d;
      tx_arqn_q      <= tx_arqn_d;
      tx_flow_q      <= tx_flow_d;
      rx_accept_q    <= rx_accept_d;
      rx_dup_q       <= rx_dup_d;
      rtx_abort_q    <= rtx_abort_d;
      flush_done_q   <= flush_done_d;
    end
  end

  assign tx_dec_valid = tx_dec_valid_q;
  assign tx_sel       = tx_sel_q;
  assign tx_seqn      = tx_seqn_q;
  assign tx_arqn      = tx_arqn_q;
  assign tx_flow      = tx_flow_q;
  assign rx_accept_p  = rx_accept_q;
  assign rx_dup_p     = rx_dup_q;
  assign rtx_abort_p  = rtx_abort_q;
  assign flush_done_p = flush_done_q;

endmodule

// File: tb/tb_arq_flow_engine.sv
// Directed, table-driven bench for arq_flow_engine (NLT=6 so LT 6/7 are out of range).
module tb_arq_flow_engine;
  import arq_pkg::*;

  localparam int NLT  = 6;
  localparam int LTW  = 3;
  localparam int RTXW = 8;

  logic            clk_6M = 1'b0;
  logic            rstz;
  logic            conn_new_p;
  logic [LTW-1:0]  conn_lt;
  logic [RTXW-1:0] regi_max_rtx;
  logic            rx_hdr_p, rx_py_end_p, rx_cac, rx_hec_good, rx_addressed;
  logic [LTW-1:0]  rx_lt_addr, rx_exp_lt;
  logic            rx_seqn, rx_arqn, rx_flow;
  logic [1:0]      rx_class;
  logic            rx_crc_good, rx_buf_ready;
  logic            tx_req_p;
  logic [LTW-1:0]  tx_lt;
  logic            tx_is_data;
  logic            flush_req_p;
  logic [LTW-1:0]  flush_lt;
  logic            tx_dec_valid;
  logic [1:0]      tx_sel;
  logic            tx_seqn, tx_arqn, tx_flow;
  logic            rx_accept_p, rx_dup_p, rtx_abort_p, flush_done_p;

  always #5 clk_6M = ~clk_6M;

  arq_flow_engine #(.NLT(NLT), .LTW(LTW), .RTXW(RTXW)) dut (
    .clk_6M(clk_6M), .rstz(rstz), .conn_new_p(conn_new_p), .conn_lt(conn_lt),
    .regi_max_rtx(regi_max_rtx), .rx_hdr_p(rx_hdr_p), .rx_py_end_p(rx_py_end_p),
    .rx_cac(rx_cac), .rx_hec_good(rx_hec_good), .rx_addressed(rx_addressed),
    .rx_lt_addr(rx_lt_addr), .rx_exp_lt(rx_exp_lt), .rx_seqn(rx_seqn),
    .rx_arqn(rx_arqn), .rx_flow(rx_flow), .rx_class(rx_class),
    .rx_crc_good(rx_crc_good), .rx_buf_ready(rx_buf_ready), .tx_req_p(tx_req_p),
    .tx_lt(tx_lt), .tx_is_data(tx_is_data), .flush_req_p(flush_req_p),
    .flush_lt(flush_lt), .tx_dec_valid(tx_dec_valid), .tx_sel(tx_sel),
    .tx_seqn(tx_seqn), .tx_arqn(tx_arqn), .tx_flow(tx_flow),
    .rx_accept_p(rx_accept_p), .rx_dup_p(rx_dup_p), .rtx_abort_p(rtx_abort_p),
    .flush_done_p(flush_done_p)
  );

  typedef struct {
    logic [63:0] tag;
    logic        tx;
    logic [2:0]  tx_lt;
    logic        tx_data;
    logic        hdr;
    logic        py;
    logic [2:0]  rx_lt;
    logic        rarqn, rflow, rseqn;
    logic [1:0]  cls;
    logic        crc, cac;
    logic        flush;
    logic [2:0]  flush_lt;
    logic        conn;
    logic [2:0]  conn_lt;
    logic        ev;
    logic [1:0]  esel;
    logic        eseqn, earqn, eacc, edup, eab, edone;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vq[$];

  function automatic vec_t v_idle(input logic [63:0] tag);
    vec_t v;
    v.tag = tag; v.tx = 0; v.tx_lt = 0; v.tx_data = 0; v.hdr = 0; v.py = 0;
    v.rx_lt = 0; v.rarqn = 0; v.rflow = 1; v.rseqn = 0; v.cls = 0; v.crc = 0;
    v.cac = 1; v.flush = 0; v.flush_lt = 0; v.conn = 0; v.conn_lt = 0;
    v.ev = 0; v.esel = 0; v.eseqn = 0; v.earqn = 0; v.eacc = 0; v.edup = 0;
    v.eab = 0; v.edone = 0;
    return v;
  endfunction

  function automatic vec_t v_tx(input logic [2:0] lt, input logic data, input logic [1:0] sel,
                                input logic sq, input logic aq, input logic ab, input logic [63:0] tag);
    vec_t v = v_idle(tag);
    v.tx = 1; v.tx_lt = lt; v.tx_data = data;
    v.ev = 1; v.esel = sel; v.eseqn = sq; v.earqn = aq; v.eab = ab;
    return v;
  endfunction

  function automatic vec_t v_hdr(input logic [2:0] lt, input logic aq, input logic fl,
                                 input logic done, input logic [63:0] tag);
    vec_t v = v_idle(tag);
    v.hdr = 1; v.rx_lt = lt; v.rarqn = aq; v.rflow = fl; v.edone = done;
    return v;
  endfunction

  function automatic vec_t v_py(input logic [2:0] lt, input logic sq, input logic [1:0] cls,
                                input logic crc, input logic cac, input logic acc,
                                input logic dup, input logic [63:0] tag);
    vec_t v = v_idle(tag);
    v.py = 1; v.rx_lt = lt; v.rseqn = sq; v.cls = cls; v.crc = crc; v.cac = cac;
    v.eacc = acc; v.edup = dup;
    return v;
  endfunction

  function automatic vec_t v_flush(input logic [2:0] lt, input logic [63:0] tag);
    vec_t v = v_idle(tag);
    v.flush = 1; v.flush_lt = lt;
    return v;
  endfunction

  task automatic drive_idle();
    conn_new_p = 0; conn_lt = 0; rx_hdr_p = 0; rx_py_end_p = 0; rx_cac = 1;
    rx_lt_addr = 0; rx_exp_lt = 0; rx_seqn = 0; rx_arqn = 0; rx_flow = 1;
    rx_class = 0; rx_crc_good = 0; tx_req_p = 0; tx_lt = 0; tx_is_data = 0;
    flush_req_p = 0; flush_lt = 0;
  endtask

  task automatic check_out(input logic [63:0] tag, input int idx, input logic [9:0] exp, input logic ev);
    logic [9:0] act;
    act = {tx_dec_valid, ev ? tx_sel : 2'b00, ev ? tx_seqn : 1'b0, ev ? tx_arqn : 1'b0,
           rx_accept_p, rx_dup_p, rtx_abort_p, flush_done_p, tx_flow};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got v/sel/sq/aq/acc/dup/ab/done/flow=%b required %b", tag, idx, act, exp);
    end else begin
      $display("ok   %s [%0d]: outputs %b", tag, idx, act);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk_6M);
    tx_req_p = v.tx; tx_lt = v.tx_lt; tx_is_data = v.tx_data;
    rx_hdr_p = v.hdr; rx_py_end_p = v.py; rx_lt_addr = v.rx_lt; rx_exp_lt = v.rx_lt;
    rx_arqn = v.rarqn; rx_flow = v.rflow; rx_seqn = v.rseqn; rx_class = v.cls;
    rx_crc_good = v.crc; rx_cac = v.cac; flush_req_p = v.flush; flush_lt = v.flush_lt;
    conn_new_p = v.conn; conn_lt = v.conn_lt;
    @(posedge clk_6M);
    #1;
    check_out(v.tag, idx, {v.ev, v.esel, v.eseqn, v.earqn, v.eacc, v.edup, v.eab, v.edone, 1'b1}, v.ev);
    drive_idle();
  endtask

  initial begin
    vec_t v;
    drive_idle();
    rx_hec_good = 1; rx_addressed = 1; regi_max_rtx = 8'd2;
    rstz = 0; rx_buf_ready = 0;
    repeat (3) @(posedge clk_6M);
    #1;
    check_out("reset", 0, 10'b00000_0000_1, 1'b0);
    @(negedge clk_6M);
    rstz = 1; rx_buf_ready = 1;

    // Basic TX/ACK on LT1
    vq.push_back(v_tx(1, 1, SEL_NEW, 1, 0, 0, "lt1_new"));
    vq.push_back(v_hdr(1, 1, 1, 0, "lt1_ack"));
    vq.push_back(v_tx(1, 1, SEL_NEW, 0, 0, 0, "lt1_new2"));
    // RX ARQ on LT2, observed through tx_arqn on non-data requests
    vq.push_back(v_py(2, 1, CLS_ACL, 1, 1, 1, 0, "lt2_acc"));
    vq.push_back(v_tx(2, 0, SEL_NEW, 1, 1, 0, "lt2_aq1"));
    vq.push_back(v_py(2, 1, CLS_ACL, 1, 1, 0, 1, "lt2_dup"));
    vq.push_back(v_tx(2, 0, SEL_NEW, 1, 1, 0, "lt2_aq1b"));
    vq.push_back(v_py(2, 0, CLS_ACL, 0, 1, 0, 0, "lt2_crcx"));
    vq.push_back(v_tx(2, 0, SEL_NEW, 1, 0, 0, "lt2_aq0"));
    vq.push_back(v_py(2, 0, CLS_ACL, 1, 1, 1, 0, "lt2_acc0"));
    vq.push_back(v_tx(2, 0, SEL_NEW, 1, 1, 0, "lt2_aq1c"));
    vq.push_back(v_py(2, 0, CLS_ACL, 1, 0, 0, 0, "lt2_cacx"));
    vq.push_back(v_tx(2, 0, SEL_NEW, 1, 0, 0, "lt2_aq0b"));
    vq.push_back(v_py(2, 1, CLS_ACL, 1, 1, 1, 0, "lt2_acc1"));
    vq.push_back(v_py(2, 0, CLS_NULL, 1, 1, 0, 0, "lt2_null"));
    vq.push_back(v_tx(2, 0, SEL_NEW, 1, 1, 0, "lt2_aq1d"));
    vq.push_back(v_py(2, 0, CLS_OTHER, 1, 1, 0, 0, "lt2_oth"));
    vq.push_back(v_tx(2, 0, SEL_NEW, 1, 0, 0, "lt2_aq0c"));
    // Retransmission limit on LT3
    vq.push_back(v_tx(3, 1, SEL_NEW, 1, 0, 0, "lt3_new"));
    vq.push_back(v_tx(3, 1, SEL_RETX, 1, 0, 0, "lt3_rtx1"));
    vq.push_back(v_tx(3, 1, SEL_RETX, 1, 0, 0, "lt3_rtx2"));
    vq.push_back(v_tx(3, 1, SEL_EMPTY_CONT, 1, 0, 1, "lt3_abrt"));
    vq.push_back(v_tx(3, 1, SEL_EMPTY_CONT, 1, 0, 0, "lt3_fls"));
    vq.push_back(v_hdr(3, 1, 1, 1, "lt3_done"));
    vq.push_back(v_tx(3, 1, SEL_NEW, 0, 0, 0, "lt3_new2"));
    // Flow control on LT1 (WAIT_ACK, seqn 0)
    vq.push_back(v_hdr(1, 0, 0, 0, "lt1_stop"));
    vq.push_back(v_tx(1, 1, SEL_HOLD, 0, 0, 0, "lt1_hold"));
    vq.push_back(v_hdr(1, 0, 1, 0, "lt1_go"));
    vq.push_back(v_tx(1, 1, SEL_RETX, 0, 0, 0, "lt1_rtx"));
    vq.push_back(v_flush(1, "lt1_flq"));
    vq.push_back(v_hdr(1, 0, 0, 0, "lt1_stp2"));
    vq.push_back(v_tx(1, 1, SEL_EMPTY_CONT, 0, 0, 0, "lt1_fls"));
    vq.push_back(v_hdr(1, 1, 1, 1, "lt1_done"));
    vq.push_back(v_tx(1, 1, SEL_NEW, 1, 0, 0, "lt1_new3"));
    // Flush ignored in IDLE; same-cycle collisions on LT5
    vq.push_back(v_flush(5, "lt5_flq"));
    vq.push_back(v_tx(5, 1, SEL_NEW, 1, 0, 0, "lt5_new"));
    v = v_hdr(5, 1, 1, 0, "lt5_akfl"); v.flush = 1; v.flush_lt = 5;
    vq.push_back(v);
    vq.push_back(v_tx(5, 1, SEL_NEW, 0, 0, 0, "lt5_new2"));
    v = v_tx(5, 1, SEL_RETX, 0, 0, 0, "lt5_txak"); v.hdr = 1; v.rx_lt = 5; v.rarqn = 1;
    vq.push_back(v);
    vq.push_back(v_tx(5, 1, SEL_NEW, 1, 0, 0, "lt5_new3"));
    // Out-of-range LTs
    vq.push_back(v_tx(7, 1, SEL_HOLD, 0, 0, 0, "lt7_hold"));
    vq.push_back(v_tx(6, 0, SEL_HOLD, 0, 0, 0, "lt6_hold"));
    vq.push_back(v_py(7, 1, CLS_ACL, 1, 1, 0, 0, "lt7_py"));
    // Context reset beats a same-cycle ACK on LT4; LT3 untouched
    vq.push_back(v_tx(4, 1, SEL_NEW, 1, 0, 0, "lt4_new"));
    v = v_hdr(4, 1, 1, 0, "lt4_conn"); v.conn = 1; v.conn_lt = 4;
    vq.push_back(v);
    vq.push_back(v_tx(4, 1, SEL_NEW, 1, 0, 0, "lt4_new2"));
    vq.push_back(v_tx(3, 1, SEL_RETX, 0, 0, 0, "lt3_rtx3"));
    vq.push_back(v_flush(3, "lt3_flq"));

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i + 1);

    // tx_flow follows rx_buf_ready one cycle later
    @(negedge clk_6M);
    rx_buf_ready = 0;
    @(posedge clk_6M);
    #1;
    check_out("flow_lo", 100, 10'b00000_0000_0, 1'b0);
    @(negedge clk_6M);
    rx_buf_ready = 1;

    // Reset in the middle of LT3's flush, with a request that must be ignored
    @(negedge clk_6M);
    rstz = 0; rx_buf_ready = 0; tx_req_p = 1; tx_lt = 3; tx_is_data = 1;
    @(posedge clk_6M);
    #1;
    check_out("rst_mid", 101, 10'b00000_0000_1, 1'b0);
    @(negedge clk_6M);
    rstz = 1; rx_buf_ready = 1; drive_idle();
    apply(v_tx(3, 1, SEL_NEW, 1, 0, 0, "lt3_rst"), 102);

    repeat (2) @(posedge clk_6M);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
